// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
//  if_stage_if
//  Signal bundle for the instruction-fetch stage: IROM port, hazard/redirect
//  controls from the pipeline, and the IF/ID register outputs to decode.
//  Revision: 1.0  initial release
// ============================================================================
interface if_stage_if #(
    parameter int IROM_AW = 14
);
    logic [IROM_AW-1:0] irom_addr;
    logic [31:0]        irom_din;
    logic               stall;
    logic               ex_redirect;
    logic [31:0]        ex_target;
    logic [31:0]        if_pc;
    logic [31:0]        id_pc;
    logic [31:0]        id_pc4;
    logic [31:0]        id_inst;
    logic [24:0]        id_din;
    logic [2:0]         id_sext_op;
    logic               id_valid;

    // The fetch stage itself
    modport master (
        output irom_addr, if_pc, id_pc, id_pc4, id_inst, id_din, id_sext_op, id_valid,
        input  irom_din, stall, ex_redirect, ex_target
    );

    // The surrounding pipeline / IROM
    modport slave (
        input  irom_addr, if_pc, id_pc, id_pc4, id_inst, id_din, id_sext_op, id_valid,
        output irom_din, stall, ex_redirect, ex_target
    );
endinterface
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  if_stage
//  Instruction fetch: PC register, IROM addressing and the IF/ID pipeline
//  register with load-use stall and EX redirect handling. Also decodes the
//  immediate type for the ID-stage immediate generator.
//  Revision: 1.0  initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IROM_AW  = 14
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    if_stage_if.master bus
);

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] SEXT_I     = 3'b000;
    localparam logic [2:0] SEXT_SHAMT = 3'b001;
    localparam logic [2:0] SEXT_S     = 3'b010;
    localparam logic [2:0] SEXT_B     = 3'b011;
    localparam logic [2:0] SEXT_U     = 3'b100;
    localparam logic [2:0] SEXT_J     = 3'b101;

    logic [31:0] pc;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic [2:0]  sext_op;

    // Target low bits are dropped: redirects are forced word-aligned.
    logic unused_target_bits;
    assign unused_target_bits = ^bus.ex_target[1:0];

    // PC and IF/ID update: redirect beats stall; a redirect flushes ID to a
    // bubble but leaves id_pc untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            id_pc    <= 32'h0000_0000;
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
        end else if (bus.ex_redirect) begin
            pc       <= {bus.ex_target[31:2], 2'b00};
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
        end else if (!bus.stall) begin
            pc       <= pc + 32'd4;     // wraps naturally from FFFF_FFFC to 0
            id_pc    <= pc;
            id_inst  <= bus.irom_din;
            id_valid <= 1'b1;
        end
    end

    // Immediate-type decode from opcode/funct3 of the instruction in ID.
    always_comb begin
        sext_op = SEXT_I;
        if (id_valid) begin
            case (id_inst[6:0])
                OP_IMM: begin
                    if (id_inst[14:12] == 3'b001 || id_inst[14:12] == 3'b101)
                        sext_op = SEXT_SHAMT;
                    else
                        sext_op = SEXT_I;
                end
                OP_LOAD, OP_JALR:  sext_op = SEXT_I;
                OP_STORE:          sext_op = SEXT_S;
                OP_BR:             sext_op = SEXT_B;
                OP_LUI, OP_AUIPC:  sext_op = SEXT_U;
                OP_JAL:            sext_op = SEXT_J;
                default:           sext_op = SEXT_I;
            endcase
        end
    end

    assign bus.irom_addr  = pc[IROM_AW+1:2];
    assign bus.if_pc      = pc;
    assign bus.id_pc      = id_pc;
    assign bus.id_pc4     = id_pc + 32'd4;
    assign bus.id_inst    = id_inst;
    assign bus.id_din     = id_inst[31:7];
    assign bus.id_sext_op = sext_op;
    assign bus.id_valid   = id_valid;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  tb_if_stage
//  Directed, table-driven bench for if_stage with a small IROM model.
//  Revision: 1.0  initial release
// ============================================================================
module tb_if_stage;

    logic clk;
    logic rst_n;

    if_stage_if #(.IROM_AW(14)) bus();

    if_stage #(.RESET_PC(32'h0000_0000), .IROM_AW(14)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // IROM model: 256 words, aliased on the low address bits
    logic [31:0] rom [0:255];
    assign bus.irom_din = rom[bus.irom_addr[7:0]];

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] tgt;
        logic [31:0] e_if_pc;
        logic [31:0] e_id_pc;
        logic [31:0] e_inst;
        logic        e_valid;
        logic [2:0]  e_sext;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    int checks;
    int failures;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_if_pc,
                             input logic [31:0] e_id_pc, input logic [31:0] e_inst,
                             input logic e_valid, input logic [2:0] e_sext);
        logic [31:0] e_pc4;
        logic [24:0] e_din;
        logic [13:0] e_addr;
        e_pc4  = e_id_pc + 32'd4;
        e_din  = e_inst[31:7];
        e_addr = e_if_pc[15:2];
        chk({tag, ".if_pc"},     bus.if_pc,              e_if_pc);
        chk({tag, ".irom_addr"}, {18'd0, bus.irom_addr}, {18'd0, e_addr});
        chk({tag, ".id_pc"},     bus.id_pc,              e_id_pc);
        chk({tag, ".id_pc4"},    bus.id_pc4,             e_pc4);
        chk({tag, ".id_inst"},   bus.id_inst,            e_inst);
        chk({tag, ".id_din"},    {7'd0, bus.id_din},     {7'd0, e_din});
        chk({tag, ".id_valid"},  {31'd0, bus.id_valid},  {31'd0, e_valid});
        chk({tag, ".id_sext"},   {29'd0, bus.id_sext_op},{29'd0, e_sext});
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        for (int i = 0; i < 256; i++) rom[i] = 32'h0000_0013;
        rom[0]   = 32'h0050_0093;   // ADDI
        rom[1]   = 32'h0010_2023;   // SW
        rom[2]   = 32'hFE00_0EE3;   // BEQ
        rom[3]   = 32'h0000_10B7;   // LUI
        rom[16]  = 32'h0000_0017;   // AUIPC   @0x40
        rom[64]  = 32'h0020_9093;   // SLLI    @0x100
        rom[65]  = 32'h0080_006F;   // JAL     @0x104
        rom[66]  = 32'h0000_0033;   // ADD     @0x108
        rom[67]  = 32'h0000_0067;   // JALR    @0x10C
        rom[255] = 32'hFE11_2E23;   // SW      @0xFFFFFFFC (aliased)

        //            stall redir target          if_pc          id_pc          id_inst        valid sext
        vecs[0]  = '{1'b0, 1'b0, 32'h0,         32'h0000_0004, 32'h0000_0000, 32'h0050_0093, 1'b1, 3'b000};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,         32'h0000_0008, 32'h0000_0004, 32'h0010_2023, 1'b1, 3'b010};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,         32'h0000_0008, 32'h0000_0004, 32'h0010_2023, 1'b1, 3'b010};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,         32'h0000_0008, 32'h0000_0004, 32'h0010_2023, 1'b1, 3'b010};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,         32'h0000_000C, 32'h0000_0008, 32'hFE00_0EE3, 1'b1, 3'b011};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_0103, 32'h0000_0100, 32'h0000_0008, 32'h0000_0013, 1'b0, 3'b000};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,         32'h0000_0104, 32'h0000_0100, 32'h0020_9093, 1'b1, 3'b001};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,         32'h0000_0108, 32'h0000_0104, 32'h0080_006F, 1'b1, 3'b101};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,         32'h0000_010C, 32'h0000_0108, 32'h0000_0033, 1'b1, 3'b000};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,         32'h0000_0110, 32'h0000_010C, 32'h0000_0067, 1'b1, 3'b000};
        vecs[10] = '{1'b1, 1'b1, 32'h0000_0040, 32'h0000_0040, 32'h0000_010C, 32'h0000_0013, 1'b0, 3'b000};
        vecs[11] = '{1'b1, 1'b0, 32'h0,         32'h0000_0040, 32'h0000_010C, 32'h0000_0013, 1'b0, 3'b000};
        vecs[12] = '{1'b0, 1'b0, 32'h0,         32'h0000_0044, 32'h0000_0040, 32'h0000_0017, 1'b1, 3'b100};
        vecs[13] = '{1'b0, 1'b1, 32'h0000_000C, 32'h0000_000C, 32'h0000_0040, 32'h0000_0013, 1'b0, 3'b000};
        vecs[14] = '{1'b0, 1'b0, 32'h0,         32'h0000_0010, 32'h0000_000C, 32'h0000_10B7, 1'b1, 3'b100};
        vecs[15] = '{1'b0, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_000C, 32'h0000_0013, 1'b0, 3'b000};
        vecs[16] = '{1'b0, 1'b0, 32'h0,         32'h0000_0000, 32'hFFFF_FFFC, 32'hFE11_2E23, 1'b1, 3'b010};
        vecs[17] = '{1'b0, 1'b0, 32'h0,         32'h0000_0004, 32'h0000_0000, 32'h0050_0093, 1'b1, 3'b000};

        // Reset
        rst_n           = 1'b0;
        bus.stall       = 1'b0;
        bus.ex_redirect = 1'b0;
        bus.ex_target   = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 32'h0, 32'h0, 32'h0000_0013, 1'b0, 3'b000);
        rst_n = 1'b1;

        // Table-driven sequence
        for (int i = 0; i < NV; i++) begin
            bus.stall       = vecs[i].stall;
            bus.ex_redirect = vecs[i].redir;
            bus.ex_target   = vecs[i].tgt;
            @(posedge clk);
            #1;
            check_all($sformatf("v%0d", i), vecs[i].e_if_pc, vecs[i].e_id_pc,
                      vecs[i].e_inst, vecs[i].e_valid, vecs[i].e_sext);
        end

        // Asynchronous reset in the middle of a stall
        bus.stall       = 1'b1;
        bus.ex_redirect = 1'b0;
        @(posedge clk);
        #1;
        check_all("stall_pre_rst", 32'h4, 32'h0, 32'h0050_0093, 1'b1, 3'b000);
        @(posedge clk);
        #1;
        check_all("stall_pre_rst2", 32'h4, 32'h0, 32'h0050_0093, 1'b1, 3'b000);
        #3;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 32'h0, 32'h0, 32'h0000_0013, 1'b0, 3'b000);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        bus.stall = 1'b0;
        @(posedge clk);
        #1;
        check_all("post_rst", 32'h4, 32'h0, 32'h0050_0093, 1'b1, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage and IF/ID pipeline register of the five-stage pipeline CPU. Holds the PC, drives the instruction ROM address, and latches the fetched word into the ID stage together with its PC and the immediate-type selector. The immediate generator in ID consumes `id_din` (instruction bits 31:7) and `id_sext_op` directly. Handles load-use stalls from the hazard unit and control-flow redirects from EX.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `IROM_AW`, 14, word-address width of the instruction ROM
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `irom_addr`  out  IROM_AW  word address to IROM, = `pc[IROM_AW+1:2]`
- `irom_din`  in  32  instruction word from IROM, combinational on `irom_addr`
- `stall`  in  1  hazard unit: hold PC and IF/ID
- `ex_redirect`  in  1  EX: taken branch or jump
- `ex_target`  in  32  EX: redirect target address
- `if_pc`  out  32  current fetch PC
- `id_pc`  out  32  PC of the instruction in ID
- `id_pc4`  out  32  `id_pc + 4`
- `id_inst`  out  32  instruction in ID
- `id_din`  out  25  `id_inst[31:7]`, to the immediate generator
- `id_sext_op`  out  3  immediate type for the immediate generator
- `id_valid`  out  1  ID holds a real instruction (0 = bubble)

## Operation
- The state is `pc`, plus the IF/ID register {`id_pc`, `id_inst`, `id_valid`}.
- `id_pc4` and `id_din` are combinational from the register contents.
- Update priority, evaluated on each rising edge:
  1. `ex_redirect`=1: `pc` <= `{ex_target[31:2],2'b00}`. IF/ID is flushed: `id_inst`=32'h0000_0013 (NOP), `id_valid`=0, `id_pc` keeps its old value. Redirect overrides `stall`.
  2. Else `stall`=1: `pc` and IF/ID hold.
  3. Else: `pc` <= `pc+4`, with wrap from 32'hFFFF_FFFC to 0. IF/ID loads `id_pc`<=`pc`, `id_inst`<=`irom_din`, `id_valid`<=1.
- `id_sext_op` is decoded combinationally from `id_inst[6:0]` and `id_inst[14:12]`:
  - 7'b0010011 with funct3 001 or 101 (shift-immediate): 001
  - 7'b0010011 other funct3, 7'b0000011 (load), 7'b1100111 (JALR): 000
  - 7'b0100011 (store): 010
  - 7'b1100011 (branch): 011
  - 7'b0110111 (LUI), 7'b0010111 (AUIPC): 100
  - 7'b1101111 (JAL): 101
  - any other opcode, including R-type: 000
  - when `id_valid`=0: 000
- The stage never fetches speculatively past a redirect. The instruction fetched in the redirect cycle is discarded.

## Timing
- Reset (asynchronous on `rst_n` low, released synchronously by the clock):
  - `pc`=`if_pc`=RESET_PC, `irom_addr`=RESET_PC[IROM_AW+1:2]
  - `id_pc`=0, `id_inst`=32'h0000_0013, `id_valid`=0
  - `id_pc4`=4, `id_din`=25'h0000_000, `id_sext_op`=000
- Fetch latency is 1 cycle: the word at `pc` in cycle N appears on `id_inst` in cycle N+1, with no stall or redirect.
- First valid ID instruction: the first rising edge after `rst_n` deasserts loads RESET_PC's word, so `id_valid`=1 from then on.
- Stall: any run of length k holds all outputs for exactly k cycles, then fetch resumes at the held PC. No instruction is lost or duplicated.
- Redirect penalty: the edge with `ex_redirect`=1 sets `if_pc`=target and puts a bubble in ID. The target's word reaches ID on the next edge, provided `stall`=0.
- `ex_redirect` and `stall` high together: the redirect is taken and the stall is ignored for that edge.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values immediately, without waiting for a clock edge.
- Misaligned `ex_target[1:0]`: silently cleared. No exception is raised.

## Test plan
- Reset, then 4 free-running cycles with IROM[0..3] = 32'h00500093, 32'h00102023, 32'hFE000EE3, 32'h000010B7 -> `id_pc` = 0, 4, 8, 12; `id_sext_op` = 000, 010, 011, 100; `id_valid`=1 from the first edge.
- Stall for 2 cycles while `id_pc`=4 -> `id_pc`, `id_inst` and `if_pc`=8 are held for 2 cycles. The next edge gives `id_pc`=8 with no gap or duplicate.
- `ex_redirect`=1 with `ex_target`=32'h0000_0103 while `if_pc`=12 -> next cycle: `if_pc`=32'h100, `id_valid`=0, `id_inst`=32'h13. One cycle later: `id_pc`=32'h100, `id_valid`=1.
- `ex_redirect`=1 and `stall`=1 in the same cycle, target 32'h40 -> `if_pc`=32'h40 and ID holds a bubble; the stall has no effect.
- Instructions 32'h00209093 (SLLI), 32'h0080006F (JAL) and 32'h00000033 (ADD) -> `id_sext_op` = 001, 101, 000. `id_din` equals `id_inst[31:7]` in every case.
- Assert `rst_n`=0 asynchronously mid-cycle during a stall -> all outputs take their reset values before the next edge.
